// File: rtl/cla_chunk_add_sequencer_if.sv
// Request/result bundle for cla_chunk_add_sequencer.
// The master side issues operands and consumes results; the slave side is the adder.
interface cla_chunk_add_sequencer_if #(
  parameter int WIDTH = 64
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             done_valid;
  logic             done_ready;
  logic             busy;

  modport master (
    output start_valid, a, b, c_in, sub, done_ready,
    input  start_ready, sum, c_out, overflow, done_valid, busy
  );

  modport slave (
    input  start_valid, a, b, c_in, sub, done_ready,
    output start_ready, sum, c_out, overflow, done_valid, busy
  );
endinterface

// File: rtl/cla_chunk_add_sequencer.sv
// Multi-cycle wide adder: one CHUNK-bit carry-lookahead slice per clock, carry registered between slices.
// Optional subtract support is compiled in with `define CLA_SEQ_SUB_EN.
module cla_chunk_add_sequencer #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cla_chunk_add_sequencer_if.slave      bus
);
  localparam int NCH  = WIDTH / CHUNK;
  localparam int NB   = CHUNK / 4;   // CHUNK must be a multiple of 4
  localparam int IDXW = $clog2(NCH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  a_reg, b_reg, sum_reg;
  logic              carry_reg, c_out_reg, overflow_reg;
  logic [IDXW-1:0]   idx_reg;

  logic              accept, last;
  logic [WIDTH-1:0]  b_load;
  logic              cin_load;

  logic [CHUNK-1:0]  sa, sb, g, p, c, s;
  logic [NB-1:0]     blk_g, blk_p;
  logic [NB:0]       blk_c;

`ifdef CLA_SEQ_SUB_EN
  assign b_load   = bus.sub ? ~bus.b : bus.b;
  assign cin_load = bus.sub | bus.c_in;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign b_load     = bus.b;
  assign cin_load   = bus.c_in;
`endif

  assign accept = (state_reg == IDLE) && bus.start_valid;
  assign last   = (idx_reg == IDXW'(NCH - 1));

  // ---------------- carry-lookahead slice ----------------
  assign sa = a_reg[idx_reg*CHUNK +: CHUNK];
  assign sb = b_reg[idx_reg*CHUNK +: CHUNK];
  assign g  = sa & sb;
  assign p  = sa ^ sb;

  // Second level: carry into block k as a flat sum of products over block G/P.
  function automatic logic block_carry(input logic [NB-1:0] gg, input logic [NB-1:0] pp,
                                       input logic cin, input int k);
    logic t, cc;
    t = cin;
    for (int j = 0; j < k; j++) t = t & pp[j];
    cc = t;
    for (int j = 0; j < k; j++) begin
      t = gg[j];
      for (int m = j + 1; m < k; m++) t = t & pp[m];
      cc = cc | t;
    end
    return cc;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi <= NB; gi++) begin : g_blk_carry
      assign blk_c[gi] = block_carry(blk_g, blk_p, carry_reg, gi);
    end
    for (gi = 0; gi < NB; gi++) begin : g_blk
      localparam int L = gi * 4;
      assign blk_g[gi] = g[L+3] | (p[L+3] & g[L+2]) | (p[L+3] & p[L+2] & g[L+1])
                       | (p[L+3] & p[L+2] & p[L+1] & g[L]);
      assign blk_p[gi] = &p[L+3:L];
      assign c[L]      = blk_c[gi];
      assign c[L+1]    = g[L] | (p[L] & blk_c[gi]);
      assign c[L+2]    = g[L+1] | (p[L+1] & g[L]) | (p[L+1] & p[L] & blk_c[gi]);
      assign c[L+3]    = g[L+2] | (p[L+2] & g[L+1]) | (p[L+2] & p[L+1] & g[L])
                       | (p[L+2] & p[L+1] & p[L] & blk_c[gi]);
    end
  endgenerate

  assign s = p ^ c;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start_valid) state_next = RUN;
      RUN:     if (last)            state_next = DONE;
      DONE:    if (bus.done_ready)  state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.start_ready = (state_reg == IDLE);
    bus.done_valid  = (state_reg == DONE);
    bus.busy        = (state_reg != IDLE);
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      sum_reg      <= '0;
      carry_reg    <= 1'b0;
      c_out_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      idx_reg      <= '0;
    end else if (accept) begin
      a_reg     <= bus.a;
      b_reg     <= b_load;
      carry_reg <= cin_load;
      sum_reg   <= '0;
      idx_reg   <= '0;
    end else if (state_reg == RUN) begin
      sum_reg[idx_reg*CHUNK +: CHUNK] <= s;
      carry_reg <= blk_c[NB];
      if (last) begin
        c_out_reg    <= blk_c[NB];
        overflow_reg <= c[CHUNK-1] ^ blk_c[NB];
      end else begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  assign bus.sum      = sum_reg;
  assign bus.c_out    = c_out_reg;
  assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_cla_chunk_add_sequencer.sv
// Directed bench for cla_chunk_add_sequencer (WIDTH=64, CHUNK=16); honours `define CLA_SEQ_SUB_EN.
module tb_cla_chunk_add_sequencer;
  localparam int WIDTH = 64;
  localparam int CHUNK = 16;
  localparam int NCH   = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_chunk_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

  cla_chunk_add_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic        c_in;
    logic        sub;
    logic [63:0] exp_sum;
    logic        exp_c_out;
    logic        exp_ovf;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  int cyc = 0, acc_cnt = 0, acc_prev = 0, acc_last = 0;
  logic [63:0] res_q[$];

  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus.start_valid && bus.start_ready) begin
      acc_cnt++;
      acc_prev = acc_last;
      acc_last = cyc;
    end
    if (rst_n && bus.done_valid && bus.done_ready) res_q.push_back(bus.sum);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input vec_t v);
    int n;
    n = 0;
    while (!bus.start_ready && n < 50) begin @(posedge clk); #1; n++; end
    bus.a = v.a; bus.b = v.b; bus.c_in = v.c_in; bus.sub = v.sub;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.a = ~v.a; bus.b = ~v.b; bus.c_in = ~v.c_in; bus.sub = ~v.sub;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1; lat++;
      if (bus.done_valid) break;
    end
  endtask

  task automatic handshake(input string name);
    bus.done_ready = 1'b1;
    @(posedge clk); #1;
    bus.done_ready = 1'b0;
    check({name, ".done_drop"}, 64'(bus.done_valid), 64'd0);
  endtask

  task automatic do_op(input vec_t v);
    int lat;
    start_op(v);
    wait_done(lat);
    $display("op %-10s a=%h b=%h cin=%b sub=%b -> sum=%h c_out=%b ovf=%b lat=%0d",
             v.name, v.a, v.b, v.c_in, v.sub, bus.sum, bus.c_out, bus.overflow, lat);
    check({v.name, ".latency"}, 64'(lat), 64'(NCH));
    check({v.name, ".sum"},     bus.sum, v.exp_sum);
    check({v.name, ".c_out"},   64'(bus.c_out), 64'(v.exp_c_out));
    check({v.name, ".ovf"},     64'(bus.overflow), 64'(v.exp_ovf));
    handshake(v.name);
  endtask

  vec_t vecs[8];

  initial begin
    vec_t v;
    int n, lat, base;
    logic [63:0] hs;

    vecs[0] = '{"all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{"max_pos",  64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[2] = '{"small",    64'h3, 64'h4, 1'b0, 1'b0, 64'h7, 1'b0, 1'b0};
`ifdef CLA_SEQ_SUB_EN
    vecs[3] = '{"sub",      64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
`else
    vecs[3] = '{"sub",      64'h5, 64'h7, 1'b0, 1'b1, 64'hC, 1'b0, 1'b0};
`endif
    vecs[4] = '{"chunk_cy", 64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[5] = '{"min_neg",  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[6] = '{"mixed",    64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
                64'h2222_2222_2222_2211, 1'b0, 1'b0};
    vecs[7] = '{"propagate", 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};

    bus.start_valid = 1'b0; bus.done_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.c_in = 1'b0; bus.sub = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.sum",        bus.sum, 64'h0);
    check("rst.c_out",      64'(bus.c_out), 64'd0);
    check("rst.ovf",        64'(bus.overflow), 64'd0);
    check("rst.done_valid", 64'(bus.done_valid), 64'd0);
    check("rst.busy",       64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst.start_ready", 64'(bus.start_ready), 64'd1);

    for (int i = 0; i < 8; i++) do_op(vecs[i]);

    // held result under back-pressure while start_valid stays high
    v = vecs[1];
    start_op(v);
    wait_done(lat);
    check("hold.latency", 64'(lat), 64'(NCH));
    base = acc_cnt;
    bus.a = 64'h1; bus.b = 64'h1; bus.start_valid = 1'b1; bus.done_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold.sum",         bus.sum, v.exp_sum);
      check("hold.c_out",       64'(bus.c_out), 64'(v.exp_c_out));
      check("hold.ovf",         64'(bus.overflow), 64'(v.exp_ovf));
      check("hold.start_ready", 64'(bus.start_ready), 64'd0);
      check("hold.done_valid",  64'(bus.done_valid), 64'd1);
    end
    check("hold.no_accept", 64'(acc_cnt - base), 64'd0);
    bus.start_valid = 1'b0;
    $display("op hold       sum=%h held 5 cycles", bus.sum);
    handshake("hold");

    // reset while idx == 2 aborts the operation
    v = '{"abort", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0};
    start_op(v);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("op abort      reset applied mid-run, sum=%h busy=%b", bus.sum, bus.busy);
    check("abort.sum",         bus.sum, 64'h0);
    check("abort.c_out",       64'(bus.c_out), 64'd0);
    check("abort.ovf",         64'(bus.overflow), 64'd0);
    check("abort.done_valid",  64'(bus.done_valid), 64'd0);
    check("abort.busy",        64'(bus.busy), 64'd0);
    check("abort.start_ready", 64'(bus.start_ready), 64'd1);
    v = '{"post_abort", 64'h3, 64'h4, 1'b0, 1'b0, 64'h7, 1'b0, 1'b0};
    do_op(v);

    // back-to-back operations with no back-pressure
    res_q.delete();
    base = acc_cnt;
    bus.a = 64'h3; bus.b = 64'h4; bus.c_in = 1'b0; bus.sub = 1'b0;
    bus.start_valid = 1'b1; bus.done_ready = 1'b1;
    n = 0;
    while (acc_cnt == base && n < 50) begin @(posedge clk); #1; n++; end
    bus.a = 64'h10; bus.b = 64'h20; bus.c_in = 1'b1;
    n = 0;
    while (acc_cnt == base + 1 && n < 50) begin @(posedge clk); #1; n++; end
    bus.start_valid = 1'b0;
    n = 0;
    while (res_q.size() < 2 && n < 50) begin @(posedge clk); #1; n++; end
    bus.done_ready = 1'b0;
    check("b2b.accepts", 64'(acc_cnt - base), 64'd2);
    check("b2b.period",  64'(acc_last - acc_prev), 64'(NCH + 2));
    check("b2b.results", 64'(res_q.size()), 64'd2);
    hs = (res_q.size() > 0) ? res_q[0] : 64'hDEAD;
    check("b2b.sum0", hs, 64'h7);
    hs = (res_q.size() > 1) ? res_q[1] : 64'hDEAD;
    check("b2b.sum1", hs, 64'h31);
    $display("op b2b        period=%0d results=%0d", acc_last - acc_prev, res_q.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
